fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, on ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold the PC and the IF/ID outputs.
REQ-005 halt  input  1  HALT decoded from the instruction currently on if_instr.
REQ-006 jump_en  input  1  jump redirect request.
REQ-007 jump_target  input  16  jump destination.
REQ-008 br_take  input  1  taken-branch redirect request.
REQ-009 br_target  input  16  branch destination.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  16  instruction memory address.
REQ-012 imem_ack  input  1  read data valid this cycle.
REQ-013 imem_rdata  input  16  instruction word.
REQ-014 if_instr  output  16  instruction to decode.
REQ-015 if_pc_inc  output  16  PC+2 of if_instr.
REQ-016 if_valid  output  1  if_instr is a real instruction.
REQ-017 I_op  output  5  if_instr[15:11] opcode to the decode control.
REQ-018 func  output  2  if_instr[1:0] to the decode control.
REQ-019 halted  output  1  the block is in HALT.
REQ-020 redirect_cnt  output  16  redirect count (see Configuration).

Function
REQ-021 The block SHALL implement the states RUN, WAIT and HALT.
REQ-022 In RUN with no stall, the block SHALL drive imem_req=1 and imem_addr=pc.
REQ-023 In RUN, on imem_ack with no redirect, the block SHALL register if_instr=imem_rdata, if_pc_inc=pc+2 and if_valid=1, and set pc=pc+2 (mod 2^16; 0xFFFE wraps to 0x0000).
REQ-024 In RUN without imem_ack, the block SHALL move to WAIT and hold imem_req and imem_addr stable until imem_ack.
REQ-025 In WAIT, on imem_ack, the block SHALL perform the REQ-023 update and return to RUN.
REQ-026 While a fetch is outstanding, if_valid SHALL be 0 unless stall holds a previously valid word.
REQ-027 While stall=1, the block SHALL hold pc, if_instr, if_pc_inc and if_valid, and SHALL drive imem_req=0 unless a WAIT access is outstanding.
REQ-028 An ack that arrives during stall while in WAIT SHALL be captured into an internal one-word buffer and presented when stall falls.
REQ-029 A redirect SHALL occur when br_take or jump_en is 1.
REQ-030 When br_take and jump_en are both 1, br_target SHALL take priority.
REQ-031 A redirect SHALL be applied even when stall=1.
REQ-032 On a redirect, the block SHALL set pc=target, if_instr=16'h0800 (NOP), if_valid=0, clear the buffer, enter RUN, and drop imem_req for that cycle, which cancels any outstanding access.
REQ-033 On the cycle after a redirect, any imem_ack SHALL be ignored.
REQ-034 When halt=1 with if_valid=1 and no redirect, the block SHALL enter HALT.
REQ-035 In HALT, the block SHALL freeze pc, drive imem_req=0, set if_valid=0 and halted=1.
REQ-036 HALT SHALL be left only by rst.
REQ-037 When halt and a redirect occur in the same cycle, the redirect SHALL win and halt SHALL be ignored.
REQ-038 I_op and func SHALL be combinational slices of if_instr.

Reset
REQ-039 When rst=1 at a clock edge, the block SHALL set state=RUN, pc=0x0000, if_instr=0x0800, if_pc_inc=0x0000, if_valid=0, halted=0, the buffer empty and redirect_cnt=0.
REQ-040 After a reset edge, imem_req SHALL be 1 in the first cycle with rst=0.
REQ-041 A reset mid-access SHALL abandon that access.

Configuration
REQ-042 With FETCH_PERF_EN defined, redirect_cnt SHALL increment on each redirect cycle and saturate at 0xFFFF.
REQ-043 Without FETCH_PERF_EN, redirect_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-044 Reset, ack every cycle, words 0x4001,0x4002,0x4003 -> if_pc_inc 2,4,6 on consecutive cycles, if_valid=1, I_op=5'b01000.
REQ-045 Ack delayed 3 cycles -> imem_addr stays at 0x0004 for 4 cycles, if_valid=0 until ack.
REQ-046 br_take=1 with br_target=0x0100 and jump_en=1 with jump_target=0x0200 in the same cycle -> next imem_addr=0x0100, if_instr=0x0800, redirect_cnt=1 (with FETCH_PERF_EN).
REQ-047 stall=1 for 2 cycles while an ack is outstanding -> the buffered word appears the cycle after stall falls and no word is lost or duplicated.
REQ-048 halt=1 with if_valid=1 -> halted=1, imem_req=0 and pc frozen until rst.
REQ-049 halt=1 with br_take=1 in the same cycle -> not halted, fetch resumes at br_target.
REQ-050 pc=0xFFFE with ack -> next pc=0x0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, imem request/ack handshake, IF/ID register, redirect and HALT.
// Latency: a word acked in cycle N is on if_instr/if_valid in cycle N+1; a word buffered under stall appears the cycle after stall falls.
// Backpressure: stall holds PC and IF/ID; an outstanding WAIT access completes into a one-word buffer. Optional macro: FETCH_PERF_EN (redirect counter).
`timescale 1ns/1ps

module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        br_take,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_inc,
  output logic        if_valid,
  output logic [4:0]  I_op,
  output logic [1:0]  func,
  output logic        halted,
  output logic [15:0] redirect_cnt
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] instr_nxt, pc_inc_nxt;
  logic        valid_nxt;
  logic        buf_vld, buf_vld_nxt;
  logic [15:0] buf_dat, buf_dat_nxt;
  logic [15:0] buf_pc_inc, buf_pc_inc_nxt;
  logic        ack_ign, ack_ign_nxt;

  logic        redirect;
  logic [15:0] redirect_target;
  logic        ack_ok;
  logic [15:0] pc_plus2;

  // A redirect is a no-op once halted; branch beats jump when both fire.
  assign redirect        = (state != ST_HALT) && (br_take || jump_en);
  assign redirect_target = br_take ? br_target : jump_target;
  // An ack in the cycle right after a redirect belongs to the cancelled access.
  assign ack_ok          = imem_ack && !ack_ign;
  assign pc_plus2        = pc + 16'd2;

  assign imem_addr = pc;
  assign I_op      = if_instr[15:11];
  assign func      = if_instr[1:0];
  assign halted    = (state == ST_HALT);

  // State and IF/ID register update; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pc         <= 16'h0000;
      if_instr   <= NOP_INSTR;
      if_pc_inc  <= 16'h0000;
      if_valid   <= 1'b0;
      buf_vld    <= 1'b0;
      buf_dat    <= 16'h0000;
      buf_pc_inc <= 16'h0000;
      ack_ign    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      if_instr   <= instr_nxt;
      if_pc_inc  <= pc_inc_nxt;
      if_valid   <= valid_nxt;
      buf_vld    <= buf_vld_nxt;
      buf_dat    <= buf_dat_nxt;
      buf_pc_inc <= buf_pc_inc_nxt;
      ack_ign    <= ack_ign_nxt;
    end
  end

  // Next-state and request logic: redirect first, then halt, then stall/buffer/fetch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    instr_nxt      = if_instr;
    pc_inc_nxt     = if_pc_inc;
    valid_nxt      = if_valid;
    buf_vld_nxt    = buf_vld;
    buf_dat_nxt    = buf_dat;
    buf_pc_inc_nxt = buf_pc_inc;
    ack_ign_nxt    = 1'b0;
    imem_req       = 1'b0;

    case (state)
      ST_RUN, ST_WAIT: begin
        if (redirect) begin
          // Request stays low this cycle, which cancels any outstanding access.
          state_nxt   = ST_RUN;
          pc_nxt      = redirect_target;
          instr_nxt   = NOP_INSTR;
          valid_nxt   = 1'b0;
          buf_vld_nxt = 1'b0;
          ack_ign_nxt = 1'b1;
        end else if (halt && if_valid) begin
          state_nxt = ST_HALT;
          valid_nxt = 1'b0;
        end else if (state == ST_RUN) begin
          if (!stall) begin
            if (buf_vld) begin
              // Drain the word captured under stall before fetching again.
              instr_nxt   = buf_dat;
              pc_inc_nxt  = buf_pc_inc;
              valid_nxt   = 1'b1;
              buf_vld_nxt = 1'b0;
            end else begin
              imem_req = 1'b1;
              if (ack_ok) begin
                instr_nxt  = imem_rdata;
                pc_inc_nxt = pc_plus2;
                valid_nxt  = 1'b1;
                pc_nxt     = pc_plus2;
              end else begin
                state_nxt = ST_WAIT;
                valid_nxt = 1'b0;
              end
            end
          end
        end else begin
          // WAIT keeps the access alive even under stall so the ack is not lost.
          imem_req = 1'b1;
          if (ack_ok && stall) begin
            buf_vld_nxt    = 1'b1;
            buf_dat_nxt    = imem_rdata;
            buf_pc_inc_nxt = pc_plus2;
            pc_nxt         = pc_plus2;
            state_nxt      = ST_RUN;
          end else if (ack_ok) begin
            instr_nxt  = imem_rdata;
            pc_inc_nxt = pc_plus2;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_plus2;
            state_nxt  = ST_RUN;
          end else if (!stall) begin
            valid_nxt = 1'b0;
          end
        end
      end
      ST_HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [15:0] redirect_cnt_q;

  // Saturating count of applied redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= 16'h0000;
    end else if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
`else
  assign redirect_cnt = 16'h0000;
`endif

endmodule
